// File: rtl/hazard3_clint_pkg.sv
// Shared constants and types for the CLINT-style machine timer / software-IRQ block.
package hazard3_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CTRL_ADDR     = 16'hBFF0;
    localparam logic [15:0] MTIME_ADDR    = 16'hBFF8;
    localparam logic [15:0] MTIMEH_ADDR   = 16'hBFFC;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_DBG_STOP = 1;
    localparam logic [1:0]  CTRL_RESET    = 2'b11;

    localparam int unsigned N_HARTS_MAX   = 32;

    typedef enum logic [0:0] {
        StIdle,
        StResp
    } apb_state_e;

    typedef enum logic [2:0] {
        RegNone,
        RegMsip,
        RegCmpLo,
        RegCmpHi,
        RegCtrl,
        RegMtime,
        RegMtimeh
    } reg_sel_e;

endpackage

// File: rtl/hazard3_clint_cmp.sv
// Per-hart mtimecmp register with a registered unsigned compare against mtime.
module hazard3_clint_cmp (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wdata,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [63:0] i_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_timer_irq
);

    logic [63:0] r_cmp;
    logic        r_irq;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmp <= '1;
            r_irq <= 1'b0;
        end else begin
            if (i_we_lo) r_cmp[31:0]  <= i_wdata;
            if (i_we_hi) r_cmp[63:32] <= i_wdata;
            r_irq <= (i_mtime >= r_cmp);
        end
    end

    assign o_mtimecmp  = r_cmp;
    assign o_timer_irq = r_irq;

endmodule

// File: rtl/hazard3_clint_timer.sv
// CLINT-style shared mtime, per-hart mtimecmp/msip, on a one-wait-state APB slave.
module hazard3_clint_timer
    import hazard3_clint_pkg::*;
#(
    parameter int unsigned N_HARTS  = 2,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [15:0]        i_paddr,
    input  logic               i_psel,
    input  logic               i_penable,
    input  logic               i_pwrite,
    input  logic [31:0]        i_pwdata,
    output logic [31:0]        o_prdata,
    output logic               o_pready,
    output logic               o_pslverr,
    input  logic               i_dbg_halt,
    input  logic               i_tick,
    output logic [N_HARTS-1:0] o_soft_irq,
    output logic [N_HARTS-1:0] o_timer_irq
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    apb_state_e   r_state, w_state_next;
    logic [31:0]  r_prdata;
    logic         r_pslverr;
    logic [63:0]  r_mtime, w_mtime_d, w_mtime_inc;
    logic [31:0]  r_shadow;
    logic [15:0]  r_presc, w_presc_d;
    logic [1:0]   r_ctrl;
    logic [N_HARTS-1:0] r_msip;

    reg_sel_e     w_sel;
    logic [11:0]  w_hart;
    logic         w_err, w_access, w_wr, w_rd, w_qual, w_inc;
    logic [31:0]  w_rdata;
    logic [N_HARTS-1:0] w_hart_hit, w_timer_irq;
    logic [63:0]  w_cmp [N_HARTS];

    assign w_access = i_psel & i_penable & (r_state == StIdle);
    assign w_wr     = w_access & i_pwrite & ~w_err;
    assign w_rd     = w_access & ~i_pwrite & ~w_err;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_access) w_state_next = StResp;
            StResp: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Hart index is range-checked here so array lookups below never go out of bounds.
    always_comb begin
        w_sel  = RegNone;
        w_err  = 1'b1;
        w_hart = '0;
        if (i_paddr[1:0] == 2'b00) begin
            if (i_paddr[15:14] == MSIP_BASE[15:14]) begin
                w_hart = i_paddr[13:2];
                if (w_hart < 12'(N_HARTS) && w_hart < 12'(N_HARTS_MAX)) begin
                    w_sel = RegMsip;
                    w_err = 1'b0;
                end
            end else if (i_paddr[15:14] == MTIMECMP_BASE[15:14]) begin
                w_hart = {1'b0, i_paddr[13:3]};
                if (w_hart < 12'(N_HARTS) && w_hart < 12'(N_HARTS_MAX)) begin
                    w_sel = i_paddr[2] ? RegCmpHi : RegCmpLo;
                    w_err = 1'b0;
                end
            end else if (i_paddr == CTRL_ADDR) begin
                w_sel = RegCtrl;
                w_err = 1'b0;
            end else if (i_paddr == MTIME_ADDR) begin
                w_sel = RegMtime;
                w_err = 1'b0;
            end else if (i_paddr == MTIMEH_ADDR) begin
                w_sel = RegMtimeh;
                w_err = 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            RegMsip: begin
                for (int unsigned h = 0; h < N_HARTS; h++) begin
                    if (w_hart_hit[h]) w_rdata[0] = r_msip[h];
                end
            end
            RegCmpLo: begin
                for (int unsigned h = 0; h < N_HARTS; h++) begin
                    if (w_hart_hit[h]) w_rdata = w_cmp[h][31:0];
                end
            end
            RegCmpHi: begin
                for (int unsigned h = 0; h < N_HARTS; h++) begin
                    if (w_hart_hit[h]) w_rdata = w_cmp[h][63:32];
                end
            end
            RegCtrl:   w_rdata = {30'b0, r_ctrl};
            RegMtime:  w_rdata = r_mtime[31:0];
            RegMtimeh: w_rdata = r_shadow;
            default:   w_rdata = '0;
        endcase
    end

    assign w_qual      = i_tick & r_ctrl[CTRL_EN] & ~(i_dbg_halt & r_ctrl[CTRL_DBG_STOP]);
    assign w_inc       = w_qual & (r_presc == PRESC_MAX);
    assign w_mtime_inc = r_mtime + 64'd1;

    always_comb begin
        w_presc_d = r_presc;
        if (w_wr && w_sel == RegCtrl) begin
            w_presc_d = '0;
        end else if (w_qual) begin
            w_presc_d = (r_presc == PRESC_MAX) ? 16'd0 : r_presc + 16'd1;
        end
    end

    // A bus write owns its half outright; an increment never carries across it.
    always_comb begin
        w_mtime_d = w_inc ? w_mtime_inc : r_mtime;
        if (w_wr && w_sel == RegMtime) begin
            w_mtime_d = {r_mtime[63:32], i_pwdata};
        end else if (w_wr && w_sel == RegMtimeh) begin
            w_mtime_d = {i_pwdata, (w_inc ? w_mtime_inc[31:0] : r_mtime[31:0])};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_mtime   <= '0;
            r_shadow  <= '0;
            r_presc   <= '0;
            r_ctrl    <= CTRL_RESET;
            r_msip    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_prdata  <= w_rd ? w_rdata : 32'd0;
            r_pslverr <= w_access & w_err;
            r_mtime   <= w_mtime_d;
            r_presc   <= w_presc_d;
            if (w_rd && w_sel == RegMtime) r_shadow <= r_mtime[63:32];
            if (w_wr && w_sel == RegCtrl)  r_ctrl <= i_pwdata[1:0];
            if (w_wr && w_sel == RegMsip) begin
                r_msip <= (r_msip & ~w_hart_hit) | (w_hart_hit & {N_HARTS{i_pwdata[0]}});
            end
        end
    end

    for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
        assign w_hart_hit[h] = (w_hart == 12'(h));

        hazard3_clint_cmp u_cmp (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_wdata     (i_pwdata),
            .i_we_lo     (w_wr && w_sel == RegCmpLo && w_hart_hit[h]),
            .i_we_hi     (w_wr && w_sel == RegCmpHi && w_hart_hit[h]),
            .i_mtime     (r_mtime),
            .o_mtimecmp  (w_cmp[h]),
            .o_timer_irq (w_timer_irq[h])
        );
    end

    assign o_prdata    = r_prdata;
    assign o_pready    = (r_state == StResp);
    assign o_pslverr   = r_pslverr;
    assign o_soft_irq  = r_msip;
    assign o_timer_irq = w_timer_irq;

endmodule

// File: tb/tb_hazard3_clint_timer.sv
// Directed bench for hazard3_clint_timer with N_HARTS=2, TICK_DIV=4.
module tb_hazard3_clint_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        dbg_halt = 1'b0, tick = 1'b0;
    logic [1:0]  soft_irq, timer_irq;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    hazard3_clint_timer #(
        .N_HARTS  (2),
        .TICK_DIV (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_paddr     (paddr),
        .i_psel      (psel),
        .i_penable   (penable),
        .i_pwrite    (pwrite),
        .i_pwdata    (pwdata),
        .o_prdata    (prdata),
        .o_pready    (pready),
        .o_pslverr   (pslverr),
        .i_dbg_halt  (dbg_halt),
        .i_tick      (tick),
        .o_soft_irq  (soft_irq),
        .o_timer_irq (timer_irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        int n;
        step();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        step();
        penable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!pready && n < 8);
        check("pready", pready, 1'b1);
        rdata = prdata;
        err   = pslverr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [15:0] addr, input logic [31:0] data,
                      input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb(1'b1, addr, data, d, e);
        check({tag, "_err"}, e, exp_err);
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [31:0] exp,
                      input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb(1'b0, addr, 32'd0, d, e);
        check(tag, d, exp);
        check({tag, "_err"}, e, exp_err);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) step();
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_soft", soft_irq, 2'b00);
        check("rst_timer", timer_irq, 2'b00);
        rst = 1'b0;
        rd("cmp0_lo", 16'h4000, 32'hFFFF_FFFF, 1'b0);
        rd("cmp1_hi", 16'h400C, 32'hFFFF_FFFF, 1'b0);
        rd("ctrl_rst", 16'hBFF0, 32'h3, 1'b0);
        rd("mtime_rst", 16'hBFF8, 32'h0, 1'b0);

        // Prescaled timebase and enable
        ticks(40);
        rd("mtime_10", 16'hBFF8, 32'd10, 1'b0);
        rd("mtimeh_10", 16'hBFFC, 32'd0, 1'b0);
        wr("ctrl_off", 16'hBFF0, 32'h0, 1'b0);
        ticks(20);
        rd("mtime_frozen", 16'hBFF8, 32'd10, 1'b0);
        wr("ctrl_on", 16'hBFF0, 32'h3, 1'b0);

        // Low-word carry and shadowed high-word read
        wr("mt_lo", 16'hBFF8, 32'hFFFF_FFFF, 1'b0);
        wr("ctrl_p0", 16'hBFF0, 32'h3, 1'b0);
        ticks(4);
        rd("carry_lo", 16'hBFF8, 32'h0, 1'b0);
        rd("carry_hi", 16'hBFFC, 32'h1, 1'b0);
        wr("mth_7", 16'hBFFC, 32'h7, 1'b0);
        rd("shadow_stale", 16'hBFFC, 32'h1, 1'b0);
        rd("lo_relatch", 16'hBFF8, 32'h0, 1'b0);
        rd("shadow_new", 16'hBFFC, 32'h7, 1'b0);

        // Increment concurrent with an MTIMEH write
        wr("mth_0", 16'hBFFC, 32'h0, 1'b0);
        wr("mt_lo2", 16'hBFF8, 32'hFFFF_FFFF, 1'b0);
        wr("ctrl_p1", 16'hBFF0, 32'h3, 1'b0);
        step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'hBFFC; pwdata = 32'h5;
        tick = 1'b1;
        step();
        step();
        step();
        penable = 1'b1;
        step();
        tick = 1'b0;
        check("cc_pready", pready, 1'b1);
        check("cc_err", pslverr, 1'b0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rd("cc_lo", 16'hBFF8, 32'h0, 1'b0);
        rd("cc_hi", 16'hBFFC, 32'h5, 1'b0);

        // Timer compare on hart 1
        wr("cmp1_lo", 16'h4008, 32'h20, 1'b0);
        wr("cmp1_hi", 16'h400C, 32'h0, 1'b0);
        wr("mth_z", 16'hBFFC, 32'h0, 1'b0);
        wr("mt_1f", 16'hBFF8, 32'h1F, 1'b0);
        wr("ctrl_p2", 16'hBFF0, 32'h3, 1'b0);
        check("irq_below", timer_irq, 2'b00);
        ticks(4);
        check("irq_lat", timer_irq, 2'b00);
        step();
        check("irq_set", timer_irq, 2'b10);
        rd("cmp1_rb", 16'h4008, 32'h20, 1'b0);
        wr("cmp1_raise", 16'h4008, 32'h100, 1'b0);
        check("irq_hold", timer_irq, 2'b10);
        step();
        check("irq_clr", timer_irq, 2'b00);

        // Software IRQ and error responses
        wr("msip1", 16'h0004, 32'h1, 1'b0);
        step();
        check("soft_set", soft_irq, 2'b10);
        wr("msip0_hi", 16'h0000, 32'hFFFF_FFFE, 1'b0);
        step();
        check("soft_bit0", soft_irq, 2'b10);
        wr("msip2", 16'h0008, 32'h1, 1'b1);
        step();
        check("soft_noerrw", soft_irq, 2'b10);
        rd("misalign", 16'h0002, 32'h0, 1'b1);
        rd("msip1_rb", 16'h0004, 32'h1, 1'b0);
        rd("unmapped", 16'hBFF4, 32'h0, 1'b1);
        rd("cmp2", 16'h4010, 32'h0, 1'b1);

        // pready lasts one cycle even with psel held
        step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'hBFF0;
        step();
        penable = 1'b1;
        step();
        check("hold_rdy", pready, 1'b1);
        check("hold_data", prdata, 32'h3);
        step();
        check("hold_1cyc", pready, 1'b0);
        psel = 1'b0; penable = 1'b0;
        step();
        step();

        // Debug halt
        wr("ctrl_dbg", 16'hBFF0, 32'h3, 1'b0);
        dbg_halt = 1'b1;
        ticks(8);
        rd("dbg_stop", 16'hBFF8, 32'h20, 1'b0);
        wr("ctrl_nodbg", 16'hBFF0, 32'h1, 1'b0);
        ticks(8);
        rd("dbg_run", 16'hBFF8, 32'h22, 1'b0);
        dbg_halt = 1'b0;

        // Reset during a write access phase
        step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h1;
        step();
        penable = 1'b1;
        rst = 1'b1;
        step();
        check("rst_mid_rdy", pready, 1'b0);
        check("rst_mid_soft", soft_irq, 2'b00);
        rst = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        step();
        check("rst_mid_rdy2", pready, 1'b0);
        rd("rst_msip0", 16'h0000, 32'h0, 1'b0);
        rd("rst_ctrl", 16'hBFF0, 32'h3, 1'b0);
        rd("rst_cmp1", 16'h4008, 32'hFFFF_FFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
